// File: rtl/fetch_ctrl.sv
// fetch_ctrl: program-counter / fetch sequencer with IDLE, RUN and HALT states.
// Drives the instruction ROM address, counts retired instructions (saturating)
// and reports fetch_valid / done.
// Optional feature: define FETCH_CTRL_REL_BRANCH_EN to make taken branches
// PC-relative (target is a signed offset); otherwise target is absolute.
module fetch_ctrl #(
  parameter int D  = 12,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          stall,
  input  logic          halt_req,
  input  logic          branch_taken,
  input  logic [D-1:0]  target,
  output logic [D-1:0]  progCtr,
  output logic          fetch_valid,
  output logic          done,
  output logic [CW-1:0] instr_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [D-1:0]  PC_ONE  = {{(D-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic [1:0]    state_reg, state_next;
  logic [D-1:0]  pc_reg, pc_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [CW-1:0] cnt_inc;
  logic [D-1:0]  branch_dest;

  // Saturating increment of the retired-instruction counter.
  always_comb begin
    cnt_inc = cnt_reg;
    if (cnt_reg != CNT_MAX) begin
      cnt_inc = cnt_reg + CNT_ONE;
    end
  end

  // Branch destination: absolute target or PC plus two's-complement offset.
  // The sum naturally wraps modulo 2**D since it is D bits wide.
  always_comb begin
`ifdef FETCH_CTRL_REL_BRANCH_EN
    branch_dest = pc_reg + target;
`else
    branch_dest = target;
`endif
  end

  // Next-state logic; in RUN the priority is stall, halt, branch, increment.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        pc_next  = '0;
        cnt_next = '0;
        if (start) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stall) begin
          // Everything frozen; halt and branch requests are dropped.
          state_next = ST_RUN;
        end else if (halt_req) begin
          state_next = ST_HALT;
          cnt_next   = cnt_inc;
        end else if (branch_taken) begin
          pc_next  = branch_dest;
          cnt_next = cnt_inc;
        end else begin
          pc_next  = pc_reg + PC_ONE;
          cnt_next = cnt_inc;
        end
      end
      ST_HALT: begin
        if (start) begin
          state_next = ST_RUN;
          pc_next    = '0;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = ST_IDLE;
        pc_next    = '0;
        cnt_next   = '0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset into IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      pc_reg    <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Status outputs depend only on state and stall, never on other inputs.
  always_comb begin
    fetch_valid = (state_reg == ST_RUN) && !stall;
    done        = (state_reg == ST_HALT);
  end

  assign progCtr     = pc_reg;
  assign instr_count = cnt_reg;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: scenario tasks drive stimulus and push expected results into
// a scoreboard; a monitor pops and compares after every rising edge.
// A second instance with a narrow counter exercises counter saturation.
module tb_fetch_ctrl;

  localparam int D   = 12;
  localparam int CW  = 16;
  localparam int CWS = 4;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           start = 1'b0;
  logic           stall = 1'b0;
  logic           halt_req = 1'b0;
  logic           branch_taken = 1'b0;
  logic [D-1:0]   target = '0;
  logic [D-1:0]   pc_a, pc_b;
  logic           fv_a, fv_b, done_a, done_b;
  logic [CW-1:0]  cnt_a;
  logic [CWS-1:0] cnt_b;

  fetch_ctrl #(.D(D), .CW(CW)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stall(stall),
    .halt_req(halt_req), .branch_taken(branch_taken), .target(target),
    .progCtr(pc_a), .fetch_valid(fv_a), .done(done_a), .instr_count(cnt_a)
  );

  fetch_ctrl #(.D(D), .CW(CWS)) u_sat (
    .clk(clk), .reset_n(reset_n), .start(start), .stall(stall),
    .halt_req(halt_req), .branch_taken(branch_taken), .target(target),
    .progCtr(pc_b), .fetch_valid(fv_b), .done(done_b), .instr_count(cnt_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int             id;
    logic [D-1:0]   pc;
    logic [CW-1:0]  cnt;
    logic [CWS-1:0] cnt4;
    logic           done;
    logic           fv;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  int txn = 0;

  // Reference model: 0 = IDLE, 1 = RUN, 2 = HALT.
  int             m_state = 0;
  logic [D-1:0]   m_pc = '0;
  logic [CW-1:0]  m_cnt = '0;
  logic [CWS-1:0] m_cnt4 = '0;

  task automatic model_reset();
    m_state = 0;
    m_pc = '0;
    m_cnt = '0;
    m_cnt4 = '0;
  endtask

  task automatic model_retire();
    if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
    if (m_cnt4 != {CWS{1'b1}}) m_cnt4 = m_cnt4 + 1'b1;
  endtask

  // One clock of stimulus: drive at negedge, predict, push, wait for the monitor.
  task automatic step(input logic s, input logic st, input logic h,
                      input logic b, input logic [D-1:0] t);
    exp_t e;
    @(negedge clk);
    start = s; stall = st; halt_req = h; branch_taken = b; target = t;
    case (m_state)
      0: if (s) begin m_state = 1; m_pc = '0; m_cnt = '0; m_cnt4 = '0; end
      1: begin
        if (st) begin
        end else if (h) begin
          m_state = 2; model_retire();
        end else if (b) begin
`ifdef FETCH_CTRL_REL_BRANCH_EN
          m_pc = m_pc + t;
`else
          m_pc = t;
`endif
          model_retire();
        end else begin
          m_pc = m_pc + 1'b1; model_retire();
        end
      end
      default: if (s) begin m_state = 1; m_pc = '0; m_cnt = '0; m_cnt4 = '0; end
    endcase
    e.id = txn; e.pc = m_pc; e.cnt = m_cnt; e.cnt4 = m_cnt4;
    e.done = (m_state == 2); e.fv = (m_state == 1) && !st;
    txn++;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic goto_pc(input logic [D-1:0] addr);
    logic [D-1:0] t;
`ifdef FETCH_CTRL_REL_BRANCH_EN
    t = addr - m_pc;
`else
    t = addr;
`endif
    step(1'b0, 1'b0, 1'b0, 1'b1, t);
  endtask

  // Scoreboard monitor: compares both instances one time unit after each edge.
  exp_t mon_e;
  always begin
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      $display("txn %0d: pc=%h cnt=%0d cnt4=%0d done=%b fv=%b", mon_e.id,
               pc_a, cnt_a, cnt_b, done_a, fv_a);
      checks++;
      if (pc_a !== mon_e.pc || pc_b !== mon_e.pc) begin
        errors++;
        $display("FAIL sb_pc txn %0d: got %h/%h expected %h", mon_e.id, pc_a, pc_b, mon_e.pc);
      end
      checks++;
      if (cnt_a !== mon_e.cnt) begin
        errors++;
        $display("FAIL sb_cnt txn %0d: got %0d expected %0d", mon_e.id, cnt_a, mon_e.cnt);
      end
      checks++;
      if (cnt_b !== mon_e.cnt4) begin
        errors++;
        $display("FAIL sb_cnt_sat txn %0d: got %0d expected %0d", mon_e.id, cnt_b, mon_e.cnt4);
      end
      checks++;
      if (done_a !== mon_e.done || done_b !== mon_e.done) begin
        errors++;
        $display("FAIL sb_done txn %0d: got %b/%b expected %b", mon_e.id, done_a, done_b, mon_e.done);
      end
      checks++;
      if (fv_a !== mon_e.fv || fv_b !== mon_e.fv) begin
        errors++;
        $display("FAIL sb_fetch_valid txn %0d: got %b/%b expected %b", mon_e.id, fv_a, fv_b, mon_e.fv);
      end
    end
  end

  task automatic test_reset();
    #1;
    checks++;
    if (pc_a !== 12'h000 || cnt_a !== 16'd0 || done_a !== 1'b0 || fv_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: pc=%h cnt=%0d done=%b fv=%b expected 000 0 0 0",
               pc_a, cnt_a, done_a, fv_a);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    // Must stay in IDLE without start.
    step(1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    step(1'b0, 1'b0, 1'b1, 1'b1, 12'h055);
    checks++;
    if (pc_a !== 12'h000 || fv_a !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: pc=%h fv=%b expected 000 0", pc_a, fv_a);
    end
  endtask

  task automatic test_start();
    step(1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
    checks++;
    if (pc_a !== 12'h000 || fv_a !== 1'b1) begin
      errors++;
      $display("FAIL start_entry: pc=%h fv=%b expected 000 1", pc_a, fv_a);
    end
    for (int i = 1; i <= 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
      checks++;
      if (pc_a !== D'(i)) begin
        errors++;
        $display("FAIL start_incr: pc=%h expected %h", pc_a, D'(i));
      end
    end
    checks++;
    if (cnt_a !== 16'd3) begin
      errors++;
      $display("FAIL start_count: cnt=%0d expected 3", cnt_a);
    end
  endtask

  task automatic test_stall_branch();
    step(1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    step(1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1, 12'h040);
      checks++;
      if (pc_a !== 12'h005 || cnt_a !== 16'd5 || fv_a !== 1'b0 || done_a !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: pc=%h cnt=%0d fv=%b done=%b expected 005 5 0 0",
                 pc_a, cnt_a, fv_a, done_a);
      end
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 12'h040);
`ifndef FETCH_CTRL_REL_BRANCH_EN
    checks++;
    if (pc_a !== 12'h040 || cnt_a !== 16'd6) begin
      errors++;
      $display("FAIL abs_branch: pc=%h cnt=%0d expected 040 6", pc_a, cnt_a);
    end
`endif
  endtask

`ifdef FETCH_CTRL_REL_BRANCH_EN
  task automatic test_rel_branch();
    goto_pc(12'h010);
    step(1'b0, 1'b0, 1'b0, 1'b1, 12'hFFE);
    checks++;
    if (pc_a !== 12'h00E) begin
      errors++;
      $display("FAIL rel_branch: pc=%h expected 00e", pc_a);
    end
  endtask
`endif

  task automatic test_wrap();
    goto_pc(12'hFFF);
    checks++;
    if (pc_a !== 12'hFFF) begin
      errors++;
      $display("FAIL wrap_setup: pc=%h expected fff", pc_a);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    checks++;
    if (pc_a !== 12'h000 || fv_a !== 1'b1 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL wrap: pc=%h fv=%b done=%b expected 000 1 0", pc_a, fv_a, done_a);
    end
  endtask

  task automatic test_halt_restart();
    goto_pc(12'h007);
    step(1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
    checks++;
    if (done_a !== 1'b1 || pc_a !== 12'h007 || fv_a !== 1'b0) begin
      errors++;
      $display("FAIL halt_enter: done=%b pc=%h fv=%b expected 1 007 0", done_a, pc_a, fv_a);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 12'h0AA);
    checks++;
    if (done_a !== 1'b1 || pc_a !== 12'h007) begin
      errors++;
      $display("FAIL halt_hold: done=%b pc=%h expected 1 007", done_a, pc_a);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
    checks++;
    if (pc_a !== 12'h000 || cnt_a !== 16'd0 || done_a !== 1'b0 || fv_a !== 1'b1) begin
      errors++;
      $display("FAIL restart: pc=%h cnt=%0d done=%b fv=%b expected 000 0 0 1",
               pc_a, cnt_a, done_a, fv_a);
    end
    // start is ignored while running: normal increment.
    step(1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
    checks++;
    if (pc_a !== 12'h001 || cnt_a !== 16'd1) begin
      errors++;
      $display("FAIL start_in_run: pc=%h cnt=%0d expected 001 1", pc_a, cnt_a);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 19; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    end
    checks++;
    if (cnt_b !== 4'hF || cnt_a !== 16'd20 || pc_a !== 12'h014) begin
      errors++;
      $display("FAIL saturation: cnt4=%0d cnt=%0d pc=%h expected 15 20 014", cnt_b, cnt_a, pc_a);
    end
  endtask

  task automatic test_reset_mid();
    goto_pc(12'h123);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (pc_a !== 12'h000 || fv_a !== 1'b0 || done_a !== 1'b0 || cnt_a !== 16'd0) begin
      errors++;
      $display("FAIL async_reset: pc=%h fv=%b done=%b cnt=%0d expected 000 0 0 0",
               pc_a, fv_a, done_a, cnt_a);
    end
    #1;
    reset_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    step(1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 11) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0,
           D'($urandom));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_start();
    test_stall_branch();
`ifdef FETCH_CTRL_REL_BRANCH_EN
    test_rel_branch();
`endif
    test_wrap();
    test_halt_restart();
    test_saturation();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
